// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, the default
// frame start byte and the frame header length.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_MAGIC,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } state_t;

   localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

   // MAGIC, LEN_LO, LEN_HI
   localparam int HDR_LEN = 3;

   // States that pull bytes out of the RX FIFO.
   function automatic logic consumes_bytes(state_t s);
      return (s == ST_WAIT_MAGIC) || (s == ST_LEN0) || (s == ST_LEN1) ||
             (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/boot_loader_uart_byte_fetch.sv
// RX FIFO read handshake. Issues a one-cycle rdreq when the FSM wants a byte,
// the FIFO is not empty and nothing is in flight; captures the byte on the
// edge after rdreq and presents it for one cycle with byte_valid.
//   want       in   FSM requests bytes
//   uart_empty in   FIFO empty (only blocks new reads)
//   uart_in    in   FIFO data, valid the cycle after rdreq
//   uart_rdreq out  read strobe
//   byte_valid out  one-cycle pulse, rx_byte valid
//   rx_byte    out  captured byte
module uart_byte_fetch (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       want,
   input  logic       uart_empty,
   input  logic [7:0] uart_in,
   output logic       uart_rdreq,
   output logic       byte_valid,
   output logic [7:0] rx_byte
);

   logic       pend_q, pend_d;
   logic       valid_q, valid_d;
   logic [7:0] byte_q, byte_d;

   // Also hold off while a captured byte is being consumed, so the FSM can
   // change state before the next read and never over-reads the frame.
   assign uart_rdreq = want & ~uart_empty & ~pend_q & ~valid_q;
   assign byte_valid = valid_q;
   assign rx_byte    = byte_q;

   always_comb begin
      pend_d  = uart_rdreq;
      valid_d = pend_q;
      byte_d  = pend_q ? uart_in : byte_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         byte_q  <= 8'h00;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         byte_q  <= byte_d;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Boot-time loader: holds the core stopped, reads a framed image
// (MAGIC, LEN_LO, LEN_HI, N*4 data bytes LE, 8-bit sum) from the UART RX FIFO,
// writes it into instruction memory, verifies the checksum and releases the core.
//   uart_in/uart_empty/uart_rdreq  RX FIFO read port
//   reload                         re-enter loading from RUN or ERR
//   im_we/im_addr/im_wdata         instruction-memory write port
//   core_run                       core fetch enable
//   loading                        high except in RUN and ERR
//   err                            sticky error, cleared by reload
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int         ADDR_W = 10,
   parameter logic [7:0] MAGIC  = DEFAULT_MAGIC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        uart_in,
   input  logic              uart_empty,
   output logic              uart_rdreq,
   input  logic              reload,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              core_run,
   output logic              loading,
   output logic              err
);

   localparam logic [16:0] CAP = 17'(1) << ADDR_W;

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [1:0]        lane_q, lane_d;
   logic [7:0]        csum_q, csum_d;
   logic [31:0]       word_q, word_d;
   logic              im_we_q, im_we_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [31:0]       im_wdata_q, im_wdata_d;
   logic              core_run_q, core_run_d;
   logic              loading_q, loading_d;
   logic              err_q, err_d;
   logic              bv;
   logic [7:0]        rx_byte;
   logic [15:0]       n_new;

   // loading_q is low in reset, which keeps the FIFO untouched until the
   // first edge after reset release.
   uart_byte_fetch u_fetch (
      .clk        (clk),
      .rst_n      (rst_n),
      .want       (loading_q & consumes_bytes(state_q)),
      .uart_empty (uart_empty),
      .uart_in    (uart_in),
      .uart_rdreq (uart_rdreq),
      .byte_valid (bv),
      .rx_byte    (rx_byte)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      lane_d     = lane_q;
      csum_d     = csum_q;
      word_d     = word_q;
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      n_new      = {rx_byte, len_q[7:0]};
      case (state_q)
         ST_WAIT_MAGIC: if (bv && rx_byte == MAGIC) state_d = ST_LEN0;
         ST_LEN0: if (bv) begin
            len_d[7:0] = rx_byte;
            state_d    = ST_LEN1;
         end
         ST_LEN1: if (bv) begin
            len_d = n_new;
            if (n_new == 16'd0 || {1'b0, n_new} > CAP) begin
               state_d = ST_ERR;
            end else begin
               idx_d   = '0;
               lane_d  = 2'd0;
               csum_d  = 8'h00;
               state_d = ST_DATA;
            end
         end
         ST_DATA: if (bv) begin
            word_d[{lane_q, 3'b000} +: 8] = rx_byte;
            csum_d = csum_q + rx_byte;
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
               // Present the write during the WRITE cycle itself.
               state_d    = ST_WRITE;
               im_we_d    = 1'b1;
               im_addr_d  = idx_q[ADDR_W-1:0];
               im_wdata_d = word_d;
            end
         end
         ST_WRITE: begin
            if (16'(idx_q) + 16'd1 == len_q) begin
               state_d = ST_CSUM;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_DATA;
            end
         end
         ST_CSUM: if (bv) state_d = (rx_byte == csum_q) ? ST_RUN : ST_ERR;
         ST_RUN, ST_ERR: if (reload) state_d = ST_WAIT_MAGIC;
         default: state_d = ST_WAIT_MAGIC;
      endcase
      core_run_d = (state_d == ST_RUN);
      err_d      = (state_d == ST_ERR);
      loading_d  = (state_d != ST_RUN) && (state_d != ST_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_WAIT_MAGIC;
         len_q      <= 16'h0000;
         idx_q      <= '0;
         lane_q     <= 2'd0;
         csum_q     <= 8'h00;
         word_q     <= 32'h0;
         im_we_q    <= 1'b0;
         im_addr_q  <= '0;
         im_wdata_q <= 32'h0;
         core_run_q <= 1'b0;
         loading_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         lane_q     <= lane_d;
         csum_q     <= csum_d;
         word_q     <= word_d;
         im_we_q    <= im_we_d;
         im_addr_q  <= im_addr_d;
         im_wdata_q <= im_wdata_d;
         core_run_q <= core_run_d;
         loading_q  <= loading_d;
         err_q      <= err_d;
      end
   end

   assign im_we    = im_we_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;
   assign core_run = core_run_q;
   assign loading  = loading_q;
   assign err      = err_q;

endmodule
